// File: rtl/video_pkg.sv
// Shared definitions for the video test-pattern transmitter.
package video_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHK   = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // RGB565 colour-bar palette, left to right
  localparam logic [15:0] COL_WHITE   = 16'hFFFF;
  localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COL_CYAN    = 16'h07FF;
  localparam logic [15:0] COL_GREEN   = 16'h07E0;
  localparam logic [15:0] COL_MAGENTA = 16'hF81F;
  localparam logic [15:0] COL_RED     = 16'hF800;
  localparam logic [15:0] COL_BLUE    = 16'h001F;
  localparam logic [15:0] COL_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Frame/line timing: h/v counters, IDLE/RUN control and registered sync outputs.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int H_W      = $clog2(H_ACTIVE + H_BLANK),
  parameter int V_W      = $clog2(V_SYNC + V_BP + V_ACTIVE + V_FP)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable_i,
  output logic [H_W-1:0] h_cnt_o,
  output logic [V_W-1:0] v_act_y_o,
  output logic           active_o,
  output logic           frame_start_o,
  output logic           vsync_o,
  output logic           href_o,
  output logic           de_o,
  output logic           frame_done_o,
  output logic [15:0]    frame_cnt_o,
  output logic           busy_o
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int V_ACT0  = V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_C = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_SYN_C = V_W'(V_SYNC);
  localparam logic [V_W-1:0] V_A0_C  = V_W'(V_ACT0);
  localparam logic [V_W-1:0] V_END_C = V_W'(V_ACT0 + V_ACTIVE);

  state_e         state_q;
  logic [H_W-1:0] h_q;
  logic [V_W-1:0] v_q;
  logic           busy_q;
  logic           vsync_q, href_q, frame_done_q;
  logic [15:0]    frame_cnt_q;
  logic           frame_last, active_c;

  assign frame_last    = (state_q == ST_RUN) && (h_q == H_LAST) && (v_q == V_LAST);
  assign frame_start_o = enable_i && ((state_q == ST_IDLE) || frame_last);
  assign active_c      = (state_q == ST_RUN) && (v_q >= V_A0_C) && (v_q < V_END_C) &&
                         (h_q < H_ACT_C);

  // Control FSM and raster counters; frames only start or stop at the frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          if (h_q == H_LAST) begin
            h_q <= '0;
            if (v_q == V_LAST) begin
              v_q <= '0;
              if (!enable_i) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              v_q <= v_q + 1'b1;
            end
          end else begin
            h_q <= h_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Registered sync/strobe outputs, one cycle behind the counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      vsync_q      <= (state_q == ST_RUN) && (v_q < V_SYN_C);
      href_q       <= active_c;
      frame_done_q <= frame_last;
      if (frame_last) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign h_cnt_o      = h_q;
  assign v_act_y_o    = v_q - V_A0_C;
  assign active_o     = active_c;
  assign vsync_o      = vsync_q;
  assign href_o       = href_q;
  assign de_o         = href_q;
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign busy_o       = busy_q;

endmodule

// File: rtl/video_pattern_tx.sv
// Test-pattern pixel source standing in for the camera at the head of the pipeline.
module video_pattern_tx
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 160,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int CHK_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        pre_frame_vsync,
  output logic        pre_frame_href,
  output logic        pre_frame_de,
  output logic [15:0] pre_rgb,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int H_W   = $clog2(H_ACTIVE + H_BLANK);
  localparam int V_W   = $clog2(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int SUB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(BAR_W - 1);
  localparam logic [H_W-1:0]   H_ADV_LIM = H_W'(H_ACTIVE - 1);

  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_act_y;
  logic             active, frame_start, busy_w;
  pat_e             pat_q;
  logic [15:0]      solid_q;
  logic [SUB_W-1:0] bar_sub_q;
  logic [2:0]       bar_idx_q;
  logic [7:0]       g;
  logic             chk_x, chk_y;
  logic [15:0]      pix_c, rgb_q;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_SYNC(V_SYNC),
    .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .H_W(H_W), .V_W(V_W)
  ) u_tim (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable),
    .h_cnt_o      (h_cnt),
    .v_act_y_o    (v_act_y),
    .active_o     (active),
    .frame_start_o(frame_start),
    .vsync_o      (pre_frame_vsync),
    .href_o       (pre_frame_href),
    .de_o         (pre_frame_de),
    .frame_done_o (frame_done),
    .frame_cnt_o  (frame_cnt),
    .busy_o       (busy_w)
  );

  assign busy = busy_w;

  // Pattern selection is captured only when a frame begins, so a frame is never torn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= PAT_BARS;
      solid_q <= 16'h0000;
    end else if (frame_start) begin
      pat_q   <= pat_e'(pattern_sel);
      solid_q <= solid_rgb;
    end
  end

  // Bar index tracks h_cnt via a sub-counter instead of dividing by BAR_W;
  // it is parked at 0 through blanking so every line starts on bar 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_sub_q <= '0;
      bar_idx_q <= '0;
    end else if (busy_w && (h_cnt < H_ADV_LIM)) begin
      if (bar_sub_q == SUB_LAST) begin
        bar_sub_q <= '0;
        bar_idx_q <= bar_idx_q + 3'd1;
      end else begin
        bar_sub_q <= bar_sub_q + 1'b1;
      end
    end else begin
      bar_sub_q <= '0;
      bar_idx_q <= '0;
    end
  end

  assign g     = 8'(h_cnt);
  assign chk_x = 1'(h_cnt >> CHK_SHIFT);
  assign chk_y = 1'(v_act_y >> CHK_SHIFT);

  // Pattern engine for the current raster position
  always_comb begin
    pix_c = 16'h0000;
    case (pat_q)
      PAT_BARS:  pix_c = bar_color(bar_idx_q);
      PAT_RAMP:  pix_c = {g[7:3], g[7:2], g[7:3]};
      PAT_CHK:   pix_c = (chk_x ^ chk_y) ? 16'hFFFF : 16'h0000;
      default:   pix_c = solid_q;
    endcase
  end

  // Pixel output register, aligned with the registered href/de
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= 16'h0000;
    else        rgb_q <= active ? pix_c : 16'h0000;
  end

  assign pre_rgb = rgb_q;

endmodule

// File: tb/tb_video_pattern_tx.sv
// Self-checking bench for video_pattern_tx using a frame-time reference model.
module tb_video_pattern_tx;

  localparam int HA = 16, HB = 4, VS = 1, VBP = 1, VA = 4, VFP = 1, CS = 1;
  localparam int HT = HA + HB;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int FT = HT * VT;
  localparam int VA0 = VS + VBP;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb;
  logic        pre_frame_vsync, pre_frame_href, pre_frame_de, frame_done, busy;
  logic [15:0] pre_rgb, frame_cnt;

  always #5 clk = ~clk;

  video_pattern_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BP(VBP),
    .V_ACTIVE(VA), .V_FP(VFP), .CHK_SHIFT(CS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .pre_frame_vsync(pre_frame_vsync),
    .pre_frame_href(pre_frame_href), .pre_frame_de(pre_frame_de),
    .pre_rgb(pre_rgb), .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] bar_ref(input int i);
    case (i)
      0: return 16'hFFFF; 1: return 16'hFFE0; 2: return 16'h07FF; 3: return 16'h07E0;
      4: return 16'hF81F; 5: return 16'hF800; 6: return 16'h001F; default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] pix(input int pat, input logic [15:0] sol, input int x, input int y);
    logic [7:0] gg;
    case (pat)
      0: return bar_ref(x / (HA / 8));
      1: begin gg = 8'(x % 256); return {gg[7:3], gg[7:2], gg[7:3]}; end
      2: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return sol;
    endcase
  endfunction

  int          m_t, m_pat, preset_seq, seen_seq, mh, mv;
  bit          m_run;
  logic [15:0] m_sol, preset_val;
  logic        e_vs, e_href, e_fd, e_busy;
  logic [15:0] e_rgb, e_cnt;

  initial seen_seq = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_pat = 0; m_sol = 16'h0;
      e_vs = 0; e_href = 0; e_rgb = 16'h0; e_fd = 0; e_cnt = 16'h0; e_busy = 0;
    end else begin
      if (preset_seq != seen_seq) begin
        seen_seq = preset_seq;
        e_cnt = preset_val;
      end
      mh = m_t % HT;
      mv = m_t / HT;
      e_vs   = m_run && (mv < VS);
      e_href = m_run && (mv >= VA0) && (mv < VA0 + VA) && (mh < HA);
      e_rgb  = e_href ? pix(m_pat, m_sol, mh, mv - VA0) : 16'h0000;
      e_fd   = m_run && (m_t == FT - 1);
      if (e_fd) e_cnt = e_cnt + 16'd1;
      if (!m_run) begin
        if (enable) begin m_run = 1; m_t = 0; m_pat = int'(pattern_sel); m_sol = solid_rgb; end
      end else if (m_t == FT - 1) begin
        if (enable) begin m_t = 0; m_pat = int'(pattern_sel); m_sol = solid_rgb; end
        else m_run = 0;
      end else begin
        m_t = m_t + 1;
      end
      e_busy = m_run;
    end
  end

  // ---------------- checking ----------------
  int checks = 0, failures = 0;
  int c;
  logic [15:0] r_rgb [0:1023];
  logic [15:0] r_cnt [0:1023];
  logic        r_vs [0:1023];
  logic        r_href [0:1023];
  logic        r_fd [0:1023];
  logic        r_busy [0:1023];
  logic [15:0] line0_exp [0:15] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF, 16'h07FF,
                                    16'h07E0, 16'h07E0, 16'hF81F, 16'hF81F, 16'hF800, 16'hF800,
                                    16'h001F, 16'h001F, 16'h0000, 16'h0000};

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h c=%0d t=%0t", nm, act, exp, c, $time);
    end
  endtask

  // One clock: sample at the falling edge and compare every output to the model
  task automatic tick();
    @(negedge clk);
    c++;
    if (c >= 0 && c < 1024) begin
      r_rgb[c] = pre_rgb; r_cnt[c] = frame_cnt; r_vs[c] = pre_frame_vsync;
      r_href[c] = pre_frame_href; r_fd[c] = frame_done; r_busy[c] = busy;
    end
    cmp("model_vsync", 16'(pre_frame_vsync), 16'(e_vs));
    cmp("model_href",  16'(pre_frame_href),  16'(e_href));
    cmp("model_de",    16'(pre_frame_de),    16'(e_href));
    cmp("model_rgb",   pre_rgb,              e_rgb);
    cmp("model_fdone", 16'(frame_done),      16'(e_fd));
    cmp("model_fcnt",  frame_cnt,            e_cnt);
    cmp("model_busy",  16'(busy),            16'(e_busy));
  endtask

  int n_vs, n_href, n_rise;

  initial begin
    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 16'h0;
    preset_seq = 0; preset_val = 16'h0; c = -100;
    repeat (3) tick();
    cmp("reset_busy", 16'(busy), 16'h0);
    cmp("reset_rgb", pre_rgb, 16'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    cmp("idle_vsync", 16'(pre_frame_vsync), 16'h0);

    // Frames 1..4: bars, checkerboard, solid->ramp, then stop
    enable = 1'b1; c = -1;
    while (c < 600) begin
      tick();
      case (c)
        100: pattern_sel = 2'd2;
        240: begin pattern_sel = 2'd3; solid_rgb = 16'h1234; end
        330: begin pattern_sel = 2'd1; solid_rgb = 16'hABCD; end
        470: enable = 1'b0;
        default: ;
      endcase
    end

    n_vs = 0; n_href = 0; n_rise = 0;
    for (int k = 0; k <= 140; k++) begin
      if (r_vs[k]) n_vs++;
      if (r_href[k]) n_href++;
      if (k > 0 && r_href[k] && !r_href[k-1]) n_rise++;
    end
    cmp("f1_vsync_cycles", 16'(n_vs), 16'd20);
    cmp("f1_vsync_first", 16'(r_vs[1]), 16'h1);
    cmp("f1_href_pulses", 16'(n_rise), 16'd4);
    cmp("f1_href_cycles", 16'(n_href), 16'd64);
    for (int k = 0; k < 16; k++) cmp("f1_bars_line0", r_rgb[41 + k], line0_exp[k]);
    cmp("f1_fdone_139", 16'(r_fd[139]), 16'h0);
    cmp("f1_fdone_140", 16'(r_fd[140]), 16'h1);
    cmp("f1_fcnt_140", r_cnt[140], 16'd1);
    cmp("chk_l0_x0", r_rgb[181], 16'h0000);
    cmp("chk_l0_x2", r_rgb[183], 16'hFFFF);
    cmp("chk_l2_x0", r_rgb[221], 16'hFFFF);
    cmp("solid_held", r_rgb[381], 16'h1234);
    cmp("solid_held2", r_rgb[390], 16'h1234);
    cmp("ramp_x0", r_rgb[461], 16'h0000);
    cmp("ramp_x4", r_rgb[465], 16'h0020);
    cmp("ramp_x8", r_rgb[469], 16'h0841);
    cmp("stop_busy_559", 16'(r_busy[559]), 16'h1);
    cmp("stop_busy_560", 16'(r_busy[560]), 16'h0);
    cmp("stop_fdone_560", 16'(r_fd[560]), 16'h1);
    cmp("stop_fcnt_560", r_cnt[560], 16'd4);
    n_vs = 0;
    for (int k = 561; k <= 600; k++) if (r_vs[k] || r_href[k] || r_rgb[k] != 16'h0) n_vs++;
    cmp("stop_quiet", 16'(n_vs), 16'd0);

    // Asynchronous reset in the middle of an active line
    enable = 1'b1; pattern_sel = 2'd0; c = -1;
    while (c < 45) tick();
    cmp("mid_href", 16'(pre_frame_href), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_vsync", 16'(pre_frame_vsync), 16'h0);
    cmp("arst_href", 16'(pre_frame_href), 16'h0);
    cmp("arst_de", 16'(pre_frame_de), 16'h0);
    cmp("arst_rgb", pre_rgb, 16'h0);
    cmp("arst_fdone", 16'(frame_done), 16'h0);
    cmp("arst_fcnt", frame_cnt, 16'h0);
    cmp("arst_busy", 16'(busy), 16'h0);
    enable = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    cmp("post_rst_idle", 16'(busy), 16'h0);
    cmp("post_rst_vsync", 16'(pre_frame_vsync), 16'h0);

    // Frame counter wrap from 0xFFFF
    enable = 1'b1; c = -1;
    while (c < 140) begin
      tick();
      if (c == 30) begin
        force dut.u_tim.frame_cnt_q = 16'hFFFF;
        preset_val = 16'hFFFF;
        preset_seq = preset_seq + 1;
      end
      if (c == 31) release dut.u_tim.frame_cnt_q;
      if (c == 100) enable = 1'b0;
    end
    cmp("wrap_cnt_139", r_cnt[139], 16'hFFFF);
    cmp("wrap_cnt_140", r_cnt[140], 16'h0000);
    cmp("wrap_fdone_140", 16'(r_fd[140]), 16'h1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
